// File: rtl/mips_store_buffer.sv
// rtl/mips_store_buffer.sv - posted-store FIFO between the MIPS core and the memory bus
// Aligned stores are queued as {address, data} and drained in order whenever the bus accepts the head.
module mips_store_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       memwrite,
   input  logic [WIDTH-1:0]           aluresult,
   input  logic [WIDTH-1:0]           readdataRT,
   output logic                       bus_valid,
   output logic [WIDTH-1:0]           bus_addr,
   output logic [WIDTH-1:0]           bus_data,
   input  logic                       bus_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       overflow,
   output logic                       align_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_addr [DEPTH];
   logic [WIDTH-1:0] mem_data [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             aligned;
   logic             push;
   logic             pop;

   assign aligned   = (aluresult[1:0] == 2'b00);
   assign bus_valid = (count != '0);
   assign full      = (count == DEPTH_C);
   assign pop       = bus_valid & bus_ready;
   // A pop in the same cycle frees the slot, so a full buffer can still accept.
   assign push      = memwrite & aligned & (~full | pop);
   assign bus_addr  = mem_addr[rptr];
   assign bus_data  = mem_data[rptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr[wptr] <= aluresult;
         mem_data[wptr] <= readdataRT;
      end
   end

   // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         align_err <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (memwrite && aligned && full && !pop) begin
            overflow <= 1'b1;
         end
         if (memwrite && !aligned) begin
            align_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mips_store_buffer.sv
// tb/tb_mips_store_buffer.sv - directed self-checking bench for mips_store_buffer
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_mips_store_buffer;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] aluresult;
   logic [31:0] readdataRT;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_data;
   logic        bus_ready;
   logic [2:0]  count;
   logic        full;
   logic        overflow;
   logic        align_err;

   int checks = 0;
   int fails  = 0;

   mips_store_buffer #(.WIDTH(32), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .aluresult  (aluresult),
      .readdataRT (readdataRT),
      .bus_valid  (bus_valid),
      .bus_addr   (bus_addr),
      .bus_data   (bus_data),
      .bus_ready  (bus_ready),
      .count      (count),
      .full       (full),
      .overflow   (overflow),
      .align_err  (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; memwrite = 1'b0; bus_ready = 1'b0;
      aluresult = '0; readdataRT = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      memwrite = 1'b1; aluresult = a; readdataRT = d;
      tick();
      memwrite = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus_valid); end
      checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (align_err !== 1'b0) begin fails++; $display("FAIL reset_align_err: got %b expected 0", align_err); end
   endtask

   task automatic test_single_store();
      do_reset();
      store(32'h0000_0010, 32'hDEAD_BEEF);
      checks++; if (bus_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", bus_valid); end
      checks++; if (bus_addr !== 32'h10) begin fails++; $display("FAIL single_addr: got %h expected 00000010", bus_addr); end
      checks++; if (bus_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h expected deadbeef", bus_data); end
      checks++; if (count !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", count); end
      tick();
      checks++; if (bus_addr !== 32'h10) begin fails++; $display("FAIL single_hold: got %h expected 00000010", bus_addr); end
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL single_drain_count: got %0d expected 0", count); end
      checks++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL single_drain_valid: got %b expected 0", bus_valid); end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) store(32'(4 * i), 32'h100 + 32'(i));
      checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d expected 4", count); end
      checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", full); end
      checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_overflow: got %b expected 1", overflow); end
      bus_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'(4 * i) || bus_data !== 32'h100 + 32'(i)) begin
            fails++; $display("FAIL fill_drain_%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                              i, bus_valid, bus_addr, bus_data, 32'(4 * i), 32'h100 + 32'(i));
         end
         tick();
      end
      bus_ready = 1'b0;
      checks++; if (bus_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL fill_empty: got v=%b c=%0d expected v=0 c=0", bus_valid, count); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp_a [4];
      exp_a[0] = 32'h104; exp_a[1] = 32'h108; exp_a[2] = 32'h10C; exp_a[3] = 32'h20;
      do_reset();
      for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      bus_ready = 1'b1;
      store(32'h20, 32'hCAFE_0020);
      checks++; if (count !== 3'd4) begin fails++; $display("FAIL pp_count: got %0d expected 4", count); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus_valid !== 1'b1 || bus_addr !== exp_a[i]) begin
            fails++; $display("FAIL pp_drain_%0d: got v=%b a=%h expected v=1 a=%h", i, bus_valid, bus_addr, exp_a[i]);
         end
         tick();
      end
      bus_ready = 1'b0;
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL pp_empty: got %0d expected 0", count); end
   endtask

   task automatic test_misaligned();
      do_reset();
      store(32'h0000_0006, 32'h1111_1111);
      checks++; if (align_err !== 1'b1) begin fails++; $display("FAIL mis_align_err: got %b expected 1", align_err); end
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL mis_count: got %0d expected 0", count); end
      store(32'h0000_0008, 32'h2222_2222);
      checks++; if (count !== 3'd1 || bus_addr !== 32'h8 || bus_data !== 32'h2222_2222) begin
         fails++; $display("FAIL mis_next_store: got c=%0d a=%h d=%h expected c=1 a=00000008 d=22222222", count, bus_addr, bus_data);
      end
      checks++; if (align_err !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b expected 1", align_err); end
   endtask

   task automatic test_wrap();
      logic [31:0] sent_a [$];
      logic [31:0] sent_d [$];
      logic [31:0] got_a [$];
      logic [31:0] got_d [$];
      int n = 0;
      int cyc = 0;
      do_reset();
      while (n < 10 || bus_valid) begin
         memwrite  = (n < 10) && (cyc % 3 != 2);
         bus_ready = (n < 10) ? cyc[0] : 1'b1;
         aluresult = 32'h200 + 32'(4 * n);
         readdataRT = 32'h5A00 + 32'(n);
         #1;
         if (memwrite) begin sent_a.push_back(aluresult); sent_d.push_back(readdataRT); n++; end
         if (bus_valid && bus_ready) begin got_a.push_back(bus_addr); got_d.push_back(bus_data); end
         @(posedge clk); #1;
         checks++; if (count > 3'd4) begin fails++; $display("FAIL wrap_count_cyc%0d: got %0d expected <=4", cyc, count); end
         cyc++;
         if (cyc > 60) begin
            checks++; fails++; $display("FAIL wrap_timeout: got %0d cycles expected drain within 60", cyc);
            break;
         end
      end
      memwrite = 1'b0; bus_ready = 1'b0;
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
      checks++; if (got_a.size() != 10) begin fails++; $display("FAIL wrap_len: got %0d expected 10", got_a.size()); end
      for (int i = 0; i < 10 && i < got_a.size(); i++) begin
         checks++; if (got_a[i] !== sent_a[i] || got_d[i] !== sent_d[i]) begin
            fails++; $display("FAIL wrap_order_%0d: got a=%h d=%h expected a=%h d=%h", i, got_a[i], got_d[i], sent_a[i], sent_d[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) store(32'h300 + 32'(4 * i), 32'(i));
      store(32'h301, 32'hBAD);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      checks++; if (count !== 3'd3 || overflow !== 1'b1 || align_err !== 1'b1) begin
         fails++; $display("FAIL mid_setup: got c=%0d ov=%b ae=%b expected c=3 ov=1 ae=1", count, overflow, align_err);
      end
      reset = 1'b1; memwrite = 1'b1; bus_ready = 1'b1; aluresult = 32'h400; readdataRT = 32'h4;
      tick();
      reset = 1'b0; memwrite = 1'b0; bus_ready = 1'b0;
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d expected 0", count); end
      checks++; if (bus_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", bus_valid); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
      checks++; if (align_err !== 1'b0) begin fails++; $display("FAIL mid_align_err: got %b expected 0", align_err); end
   endtask

   initial begin
      reset = 1'b1; memwrite = 1'b0; bus_ready = 1'b0;
      aluresult = '0; readdataRT = '0;
      #1;
      test_reset();
      test_single_store();
      test_fill_overflow();
      test_full_push_pop();
      test_misaligned();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
